// File: rtl/accum_bank_if.sv
// Request, read-port and result signals of the multi-channel accumulator bank.
// The requester drives through "master"; the accumulator bank sits on "slave".
interface accum_bank_if #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int CH_W     = 2
);
    logic                add;
    logic                clear;
    logic [CH_W-1:0]     ch;
    logic [WIDTH-1:0]    addend;
    logic [CH_W-1:0]     rd_ch;
    logic [WIDTH-1:0]    rd_data;
    logic [WIDTH-1:0]    sum;
    logic [CH_W-1:0]     sum_ch;
    logic                sum_valid;
    logic [CHANNELS-1:0] ovf;

    modport master (
        output add, clear, ch, addend, rd_ch,
        input  rd_data, sum, sum_ch, sum_valid, ovf
    );

    modport slave (
        input  add, clear, ch, addend, rd_ch,
        output rd_data, sum, sum_ch, sum_valid, ovf
    );
endinterface

// File: rtl/accum_bank.sv
// Multi-channel signed accumulator bank: two-stage add pipeline, sticky per-channel overflow.
// Define ACC_SATURATE_EN to clamp on overflow instead of wrapping.
module accum_bank #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int CH_W     = 2
) (
    input  logic        clk,
    input  logic        rst,
    accum_bank_if.slave bus
);
    localparam logic [31:0]      CH_LIM  = 32'(CHANNELS);
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic                s1_valid;
    logic                s1_add;
    logic                s1_clear;
    logic [CH_W-1:0]     s1_ch;
    logic [WIDTH-1:0]    s1_addend;

    logic [WIDTH-1:0]    acc [CHANNELS];
    logic [CHANNELS-1:0] ovf_q;
    logic [WIDTH-1:0]    sum_q;
    logic [CH_W-1:0]     sum_ch_q;
    logic                sum_valid_q;
    logic [WIDTH-1:0]    rd_data_q;

    logic [WIDTH-1:0]    operand;
    logic [WIDTH-1:0]    raw_sum;
    logic                overflow;
    logic [WIDTH-1:0]    add_result;
    logic [WIDTH-1:0]    result;
    logic                req_ok;
    logic                rd_ok;

    // Write-back lands on the same edge that registers S2's result, so the array
    // already holds S2's fresh value when the next same-channel request reaches S2.
    always_comb begin
        operand    = acc[s1_ch];
        raw_sum    = operand + s1_addend;
        overflow   = (operand[WIDTH-1] == s1_addend[WIDTH-1]) &&
                     (raw_sum[WIDTH-1] != operand[WIDTH-1]);
`ifdef ACC_SATURATE_EN
        add_result = overflow ? (operand[WIDTH-1] ? SAT_MIN : SAT_MAX) : raw_sum;
`else
        add_result = raw_sum;
`endif
        result     = s1_clear ? s1_addend : add_result;
        req_ok     = (bus.add || bus.clear) && (32'(bus.ch) < CH_LIM);
        rd_ok      = 32'(bus.rd_ch) < CH_LIM;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_add      <= 1'b0;
            s1_clear    <= 1'b0;
            s1_ch       <= '0;
            s1_addend   <= '0;
            for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
            ovf_q       <= '0;
            sum_q       <= '0;
            sum_ch_q    <= '0;
            sum_valid_q <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            s1_valid    <= req_ok;
            s1_add      <= bus.add;
            s1_clear    <= bus.clear;
            s1_ch       <= bus.ch;
            s1_addend   <= bus.addend;
            sum_valid_q <= s1_valid && s1_add;
            rd_data_q   <= rd_ok ? acc[bus.rd_ch] : '0;

            if (s1_valid) begin
                if (s1_add) begin
                    acc[s1_ch] <= result;
                    sum_q      <= result;
                    sum_ch_q   <= s1_ch;
                end else begin
                    acc[s1_ch] <= '0;
                end
                if (s1_clear) begin
                    ovf_q[s1_ch] <= 1'b0;
                end else if (overflow) begin
                    ovf_q[s1_ch] <= 1'b1;
                end
            end
        end
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.sum       = sum_q;
    assign bus.sum_ch    = sum_ch_q;
    assign bus.sum_valid = sum_valid_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_accum_bank.sv
// Bench for accum_bank: a 4-channel and a 3-channel bank driven in lockstep, checked
// against an integer reference model of the running sums and sticky overflow flags.
module tb_accum_bank;
    logic clk;
    logic rst;

    accum_bank_if #(.WIDTH(8), .CHANNELS(4), .CH_W(2)) bus4 ();
    accum_bank_if #(.WIDTH(8), .CHANNELS(3), .CH_W(2)) bus3 ();

    accum_bank #(.WIDTH(8), .CHANNELS(4), .CH_W(2)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    accum_bank #(.WIDTH(8), .CHANNELS(3), .CH_W(2)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int       nch [2] = '{4, 3};
    int       m_acc [2][4];
    bit [3:0] m_ovf [2];

    // request sampled at the previous edge, applied by the model at the next one
    bit p_add;
    bit p_clear;
    int p_ch;
    int p_addend;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_apply(input int d, output bit v, output int s, output int sch);
        int full;
        v = 1'b0;
        s = 0;
        sch = 0;
        if ((p_add || p_clear) && p_ch < nch[d]) begin
            if (p_add && p_clear) begin
                m_acc[d][p_ch] = p_addend;
                m_ovf[d][p_ch] = 1'b0;
                v = 1'b1; s = p_addend; sch = p_ch;
            end else if (p_clear) begin
                m_acc[d][p_ch] = 0;
                m_ovf[d][p_ch] = 1'b0;
            end else begin
                full = m_acc[d][p_ch] + p_addend;
                if (full > 127 || full < -128) begin
                    m_ovf[d][p_ch] = 1'b1;
`ifdef ACC_SATURATE_EN
                    full = (full > 127) ? 127 : -128;
`else
                    full = (full > 127) ? full - 256 : full + 256;
`endif
                end
                m_acc[d][p_ch] = full;
                v = 1'b1; s = full; sch = p_ch;
            end
        end
    endtask

    task automatic compare_outputs(input int d, input bit v, input int s, input int sch,
                                   input int exp_rd);
        logic       o_v;
        logic [7:0] o_sum;
        logic [1:0] o_ch;
        logic [7:0] o_rd;
        logic [3:0] o_ovf;
        o_v   = (d == 0) ? bus4.sum_valid : bus3.sum_valid;
        o_sum = (d == 0) ? bus4.sum : bus3.sum;
        o_ch  = (d == 0) ? bus4.sum_ch : bus3.sum_ch;
        o_rd  = (d == 0) ? bus4.rd_data : bus3.rd_data;
        o_ovf = (d == 0) ? bus4.ovf : {1'b0, bus3.ovf};
        check($sformatf("dut%0d sum_valid", nch[d]), 32'(o_v), 32'(v));
        if (v) begin
            check($sformatf("dut%0d sum", nch[d]), 32'(o_sum), 32'(s & 255));
            check($sformatf("dut%0d sum_ch", nch[d]), 32'(o_ch), 32'(sch));
        end
        check($sformatf("dut%0d ovf", nch[d]), 32'(o_ovf), 32'(m_ovf[d]));
        check($sformatf("dut%0d rd_data", nch[d]), 32'(o_rd), 32'(exp_rd & 255));
    endtask

    task automatic step(input bit a, input bit c, input int ch, input int ad, input int rc);
        bit v;
        int s;
        int sch;
        int exp_rd;
        bus4.add = a;  bus4.clear = c;  bus4.ch = 2'(ch);  bus4.addend = 8'(ad);  bus4.rd_ch = 2'(rc);
        bus3.add = a;  bus3.clear = c;  bus3.ch = 2'(ch);  bus3.addend = 8'(ad);  bus3.rd_ch = 2'(rc);
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            // read port sees the array as it stood before this edge's write-back
            exp_rd = (rc < nch[d]) ? m_acc[d][rc] : 0;
            model_apply(d, v, s, sch);
            compare_outputs(d, v, s, sch, exp_rd);
        end
        p_add = a; p_clear = c; p_ch = ch; p_addend = ad;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus4.add = 1'b0; bus4.clear = 1'b0; bus4.ch = '0; bus4.addend = '0; bus4.rd_ch = '0;
        bus3.add = 1'b0; bus3.clear = 1'b0; bus3.ch = '0; bus3.addend = '0; bus3.rd_ch = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) m_acc[d][i] = 0;
            m_ovf[d] = '0;
        end
        p_add = 1'b0; p_clear = 1'b0; p_ch = 0; p_addend = 0;
        check("reset dut4 sum_valid", 32'(bus4.sum_valid), 32'd0);
        check("reset dut4 sum", 32'(bus4.sum), 32'd0);
        check("reset dut4 sum_ch", 32'(bus4.sum_ch), 32'd0);
        check("reset dut4 ovf", 32'(bus4.ovf), 32'd0);
        check("reset dut4 rd_data", 32'(bus4.rd_data), 32'd0);
        check("reset dut3 sum_valid", 32'(bus3.sum_valid), 32'd0);
        check("reset dut3 ovf", 32'(bus3.ovf), 32'd0);
    endtask

    initial begin
        int a;
        int c;
        int ch;
        int ad;
        int rc;

        do_reset();

        // running total on channel 0: 2, 4, 6
        step(1, 0, 0, 2, 0);
        step(1, 0, 0, 2, 0);
        step(1, 0, 0, 2, 0);
        check("running total sum=4", 32'(bus4.sum), 32'd4);
        step(0, 0, 0, 0, 0);
        check("running total sum=6", 32'(bus4.sum), 32'd6);

        // interleaved channels 1/2/1, then read channel 2
        step(1, 0, 1, 5, 0);
        step(1, 0, 2, -3, 0);
        step(1, 0, 1, 5, 0);
        step(0, 0, 0, 0, 2);
        check("interleave sum=10 ch1", {24'd0, bus4.sum}, 32'd10);
        step(0, 0, 0, 0, 2);
        check("interleave rd_data ch2", 32'(bus4.rd_data), 32'hFD);

        // overflow on channel 3
        step(1, 0, 3, 100, 3);
        step(1, 0, 3, 100, 3);
        step(0, 0, 0, 0, 3);
`ifdef ACC_SATURATE_EN
        check("overflow saturated sum", 32'(bus4.sum), 32'h7F);
`else
        check("overflow wrapped sum", 32'(bus4.sum), 32'hC8);
`endif
        check("overflow ovf", 32'(bus4.ovf), 32'h8);

        // restart (add+clear) then clear alone on channel 3
        step(1, 1, 3, 7, 3);
        step(0, 1, 3, 0, 3);
        check("restart sum=7", 32'(bus4.sum), 32'd7);
        check("restart ovf cleared", 32'(bus4.ovf[3]), 32'd0);
        step(0, 0, 0, 0, 3);
        step(0, 0, 0, 0, 3);
        check("clear rd_data=0", 32'(bus4.rd_data), 32'd0);

        // reset with a request in flight
        step(1, 0, 0, 9, 0);
        do_reset();
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // channel 3 is out of range on the 3-channel bank
        step(1, 0, 1, 4, 0);
        step(1, 0, 3, 1, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 2);
        step(0, 0, 0, 0, 3);
        step(0, 0, 0, 0, 0);

        // randomized traffic, biased toward back-to-back hits on few channels
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                a  = ($urandom_range(0, 3) != 0) ? 1 : 0;
                c  = ($urandom_range(0, 7) == 0) ? 1 : 0;
                ch = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 3));
                ad = int'($urandom_range(0, 255)) - 128;
                rc = int'($urandom_range(0, 3));
                step(a[0], c[0], ch, ad, rc);
            end
        end
        step(0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
